// File: rtl/booth_pkg.sv
// Shared definitions for the sequential signed Booth divider.
// Holds the default operand width, FSM states and counter sizing.
package booth_pkg;

    localparam int WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    // Counter must reach 2*w iterations.
    function automatic int cnt_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/booth_divider_div_step.sv
// One combinational non-restoring divide step.
// Shifts {rem, quo} left, then adds or subtracts the divisor magnitude.
module div_step
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]       rem_i,
    input  logic [2*WIDTH-1:0]   quo_i,
    input  logic [WIDTH-1:0]     dvs_i,
    output logic [WIDTH:0]       rem_o,
    output logic [2*WIDTH-1:0]   quo_o
);

    logic [WIDTH:0] sh;

    // Shift, then subtract when rem is non-negative, otherwise add back.
    always_comb begin
        sh = {rem_i[WIDTH-1:0], quo_i[2*WIDTH-1]};
        if (rem_i[WIDTH] == 1'b0) begin
            rem_o = sh - {1'b0, dvs_i};
        end else begin
            rem_o = sh + {1'b0, dvs_i};
        end
        quo_o = {quo_i[2*WIDTH-2:0], ~rem_o[WIDTH]};
    end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed 2W/W divider, one quotient bit per cycle.
// Optional macro DIVIDER_SAT_EN saturates the quotient on overflow.
module booth_divider
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 ovf,
    output logic                 dbz
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);

    state_e             state_q;
    logic [WIDTH:0]     rem_q;
    logic [W2-1:0]      quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [CW-1:0]      cnt_q;
    logic               sa_q;
    logic               sb_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   rem_out_q;
    logic               ovf_q;
    logic               dbz_q;

    logic [WIDTH:0]     rem_d;
    logic [W2-1:0]      quo_d;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   rem_sgn;
    logic               q_neg;
    logic [W2:0]        q_sgn;
    logic [W2-WIDTH+1:0] q_top;
    logic               q_ovf;
    logic [WIDTH-1:0]   q_res;
    logic               dz;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    // Final correction, sign restoration and range check.
    always_comb begin
        rem_fix = rem_q[WIDTH] ? rem_q[WIDTH-1:0] + dvs_q
                               : rem_q[WIDTH-1:0];
        rem_sgn = sa_q ? -rem_fix : rem_fix;
        q_neg   = sa_q ^ sb_q;
        q_sgn   = q_neg ? -{1'b0, quo_q} : {1'b0, quo_q};
        q_top   = q_sgn[W2:WIDTH-1];
        q_ovf   = !((&q_top) || !(|q_top));
        dz      = (dvs_q == '0);
`ifdef DIVIDER_SAT_EN
        if (q_ovf) begin
            q_res = q_neg ? {1'b1, {(WIDTH-1){1'b0}}}
                          : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            q_res = q_sgn[WIDTH-1:0];
        end
`else
        q_res = q_sgn[WIDTH-1:0];
`endif
    end

    // Control FSM with operand capture and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_out_q <= '0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= dividend[W2-1];
                        sb_q    <= divisor[WIDTH-1];
                        quo_q   <= dividend[W2-1] ? -dividend : dividend;
                        dvs_q   <= divisor[WIDTH-1] ? -divisor : divisor;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W2 - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (dz) begin
                        quot_q    <= '1;
                        rem_out_q <= '0;
                        ovf_q     <= 1'b0;
                        dbz_q     <= 1'b1;
                    end else begin
                        quot_q    <= q_res;
                        rem_out_q <= rem_sgn;
                        ovf_q     <= q_ovf;
                        dbz_q     <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_out_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_booth_divider.sv
// Directed testbench for booth_divider (WIDTH=6).
// Expected quotients under overflow depend on DIVIDER_SAT_EN.
module tb_booth_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] dividend;
    logic [5:0]  divisor;
    logic        busy;
    logic        done;
    logic [5:0]  quotient;
    logic [5:0]  remainder;
    logic        ovf;
    logic        dbz;

    int n_cmp;
    int n_bad;
    int lat;
    int seen;

    booth_divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge; returns #1 after the accepting edge.
    task automatic start_op(input logic [11:0] a, input logic [5:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
    endtask

    task automatic chk_res(input string tag, input logic [5:0] q,
                           input logic [5:0] r, input logic o,
                           input logic z);
        chk({tag, "_lat"}, lat, 13);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_quo"}, quotient, q);
        chk({tag, "_rem"}, remainder, r);
        chk({tag, "_ovf"}, ovf, o);
        chk({tag, "_dbz"}, dbz, z);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_quo", quotient, 6'h00);
        chk("rst_rem", remainder, 6'h00);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_dbz", dbz, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 100 / 7
        start_op(12'd100, 6'd7);
        chk("p7_busy", busy, 1'b1);
        wait_done(lat);
        chk_res("p100_p7", 6'd14, 6'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pulse_len", done, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_quo", quotient, 6'd14);

        // signed combinations
        start_op(-12'sd100, 6'd7);
        wait_done(lat);
        chk_res("n100_p7", 6'h32, 6'h3E, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start_op(12'd100, -6'sd7);
        wait_done(lat);
        chk_res("p100_n7", 6'h32, 6'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start_op(-12'sd100, -6'sd7);
        wait_done(lat);
        chk_res("n100_n7", 6'd14, 6'h3E, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // boundary: quotient exactly -32, no overflow
        start_op(12'd1024, -6'sd32);
        wait_done(lat);
        chk_res("q_min", 6'h20, 6'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // overflow cases
        start_op(12'd1000, 6'd3);
        wait_done(lat);
`ifdef DIVIDER_SAT_EN
        chk_res("ovf_1000_3", 6'd31, 6'd1, 1'b1, 1'b0);
`else
        chk_res("ovf_1000_3", 6'd13, 6'd1, 1'b1, 1'b0);
`endif
        @(posedge clk);
        #1;
        start_op(12'h800, -6'sd1);
        wait_done(lat);
`ifdef DIVIDER_SAT_EN
        chk_res("ovf_min_n1", 6'd31, 6'd0, 1'b1, 1'b0);
`else
        chk_res("ovf_min_n1", 6'd0, 6'd0, 1'b1, 1'b0);
`endif
        @(posedge clk);
        #1;
        start_op(12'h800, 6'd1);
        wait_done(lat);
`ifdef DIVIDER_SAT_EN
        chk_res("ovf_min_p1", 6'h20, 6'd0, 1'b1, 1'b0);
`else
        chk_res("ovf_min_p1", 6'd0, 6'd0, 1'b1, 1'b0);
`endif
        @(posedge clk);
        #1;

        // divide by zero
        start_op(12'd50, 6'd0);
        wait_done(lat);
        chk_res("dbz", 6'h3F, 6'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        // start while busy is ignored
        start_op(12'd100, 6'd7);
        repeat (4) @(posedge clk);
        #1;
        start_op(12'd1000, 6'd3);
        dividend = 12'd555;
        divisor  = 6'd9;
        wait_done(lat);
        lat = lat + 5;
        chk_res("ignore", 6'd14, 6'd2, 1'b0, 1'b0);

        // back-to-back: start during the done cycle
        start_op(-12'sd100, 6'd7);
        chk("b2b_done_low", done, 1'b0);
        chk("b2b_busy", busy, 1'b1);
        wait_done(lat);
        chk_res("b2b", 6'h32, 6'h3E, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // reset mid-operation
        start_op(12'd100, 6'd7);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_quo", quotient, 6'd0);
        chk("mrst_rem", remainder, 6'd0);
        chk("mrst_ovf", ovf, 1'b0);
        chk("mrst_dbz", dbz, 1'b0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("mrst_no_done", seen, 0);
        start_op(-12'sd100, -6'sd7);
        wait_done(lat);
        chk_res("post_rst", 6'd14, 6'h3E, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
